calc_ctrl_fsm: RTL and testbench

//  Control unit (instance name FSM) for a 2-operand register-file/ALU calculator datapath.
//  - Sequences: load input 1, load input 2, execute one ALU op, write the result to the output.
//  - Drives the datapath select, register-file address/enable and ALU control lines.
//  - Exposes its current state CS.
//  - Moore machine: all outputs are a decode of CS only.

---
 rtl/calc_ctrl_fsm.sv | 94 +++++++++
 tb/tb_calc_ctrl_fsm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/calc_ctrl_fsm.sv
// Moore control FSM sequencing a 2-operand regfile/ALU calculator: load, load, execute, output.
// Optional macro CALC_CTRL_GO_HANDSHAKE_EN: hold in LoadOutput while Go stays high.
module calc_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       Go,
    input  logic [1:0] Op,
    output logic [3:0] CS,
    output logic [1:0] s1_mux,
    output logic [1:0] wa,
    output logic       we,
    output logic [1:0] raa,
    output logic       rea,
    output logic [1:0] rab,
    output logic       reb,
    output logic [1:0] c,
    output logic       s2_mux,
    output logic       Done
);

    localparam logic [3:0] S0 = 4'd0;
    localparam logic [3:0] S1 = 4'd1;
    localparam logic [3:0] S2 = 4'd2;
    localparam logic [3:0] S3 = 4'd3;
    localparam logic [3:0] S4 = 4'd4;
    localparam logic [3:0] S5 = 4'd5;
    localparam logic [3:0] S6 = 4'd6;
    localparam logic [3:0] S7 = 4'd7;
    localparam logic [3:0] S8 = 4'd8;

    // {s1_mux,wa,we,raa,rea,rab,reb,c,s2_mux,Done}
    localparam logic [14:0] W_WAIT = 15'b01_00_0_00_0_00_0_00_0_0;
    localparam logic [14:0] W_LD1  = 15'b11_01_1_00_0_00_0_00_0_0;
    localparam logic [14:0] W_LD2  = 15'b10_10_1_00_0_00_0_00_0_0;
    localparam logic [14:0] W_ADD  = 15'b00_11_1_01_1_10_1_11_0_0;
    localparam logic [14:0] W_SUB  = 15'b00_11_1_01_1_10_1_10_0_0;
    localparam logic [14:0] W_AND  = 15'b00_11_1_01_1_10_1_01_0_0;
    localparam logic [14:0] W_XOR  = 15'b00_11_1_01_1_10_1_00_0_0;
    localparam logic [14:0] W_OUT  = 15'b01_00_0_11_1_11_1_01_1_1;

    logic [3:0]  cs_q, cs_d;
    logic [14:0] out_word;

    always_comb begin
        cs_d = S0;
        case (cs_q)
            S0: cs_d = Go ? S1 : S0;
            S1: cs_d = S2;
            S2: cs_d = S3;
            S3: begin
                case (Op)
                    2'b11:   cs_d = S4;
                    2'b10:   cs_d = S5;
                    2'b01:   cs_d = S6;
                    default: cs_d = S7;
                endcase
            end
            S4, S5, S6, S7: cs_d = S8;
`ifdef CALC_CTRL_GO_HANDSHAKE_EN
            // Hold the result until the requester drops Go.
            S8: cs_d = Go ? S8 : S0;
`else
            S8: cs_d = S0;
`endif
            default: cs_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_q <= S0;
        end else begin
            cs_q <= cs_d;
        end
    end

    always_comb begin
        out_word = W_WAIT;
        case (cs_q)
            S1:      out_word = W_LD1;
            S2:      out_word = W_LD2;
            S4:      out_word = W_ADD;
            S5:      out_word = W_SUB;
            S6:      out_word = W_AND;
            S7:      out_word = W_XOR;
            S8:      out_word = W_OUT;
            default: out_word = W_WAIT;
        endcase
    end

    assign CS = cs_q;
    assign {s1_mux, wa, we, raa, rea, rab, reb, c, s2_mux, Done} = out_word;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Scoreboarded bench for calc_ctrl_fsm: an operation-step reference model queues expected
// {CS, output word} per edge; a monitor compares after every rising edge.
module tb_calc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Go = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [3:0] CS;
    logic [1:0] s1_mux, wa, raa, rab, c;
    logic       we, rea, reb, s2_mux, Done;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];

    // Reference model: position within one operation (0 idle .. 5 output) and latched op
    int         step = 0;
    logic [1:0] op_l = 2'b00;

    calc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Go(Go), .Op(Op), .CS(CS),
        .s1_mux(s1_mux), .wa(wa), .we(we), .raa(raa), .rea(rea),
        .rab(rab), .reb(reb), .c(c), .s2_mux(s2_mux), .Done(Done)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] expected(input int s, input logic [1:0] o);
        logic [3:0]  st;
        logic [14:0] w;
        case (s)
            0: begin st = 4'd0; w = 15'b01_00_0_00_0_00_0_00_0_0; end
            1: begin st = 4'd1; w = 15'b11_01_1_00_0_00_0_00_0_0; end
            2: begin st = 4'd2; w = 15'b10_10_1_00_0_00_0_00_0_0; end
            3: begin st = 4'd3; w = 15'b01_00_0_00_0_00_0_00_0_0; end
            4: begin
                st = 4'd4 + (4'd3 - {2'b00, o});
                w  = {2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, o, 1'b0, 1'b0};
            end
            default: begin st = 4'd8; w = 15'b01_00_0_11_1_11_1_01_1_1; end
        endcase
        return {st, w};
    endfunction

    // Drive inputs for the next edge, advance the model, queue its result
    task automatic cyc(input logic r, input logic g, input logic [1:0] o);
        @(negedge clk);
        reset = r;
        Go    = g;
        Op    = o;
        if (!r) begin
            step = 0;
        end else begin
            case (step)
                0: step = g ? 1 : 0;
                1: step = 2;
                2: step = 3;
                3: begin op_l = o; step = 4; end
                4: step = 5;
                default: begin
`ifdef CALC_CTRL_GO_HANDSHAKE_EN
                    step = g ? 5 : 0;
`else
                    step = 0;
`endif
                end
            endcase
        end
        exp_q.push_back(expected(step, op_l));
    endtask

    // Monitor
    initial begin
        logic [18:0] e;
        logic [14:0] act_w;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_w = {s1_mux, wa, we, raa, rea, rab, reb, c, s2_mux, Done};
                checks++;
                if (CS !== e[18:15]) begin
                    errors++;
                    $display("FAIL cs at %0t: got %0d want %0d", $time, CS, e[18:15]);
                end
                checks++;
                if (act_w !== e[14:0]) begin
                    errors++;
                    $display("FAIL out_word (CS=%0d) at %0t: got %b want %b",
                             CS, $time, act_w, e[14:0]);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        // reset state
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 2'b11);
        // ADD operation
        cyc(1'b1, 1'b1, 2'b11);
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b11);
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b00);
        // Go held: SUB, AND, XOR back to back
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) begin
                logic [1:0] ov;
                ov = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
                cyc(1'b1, 1'b1, (j == 3) ? ov : ~ov);
            end
        end
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b00);
        // reset while executing, then restart
        cyc(1'b1, 1'b1, 2'b11);
        cyc(1'b1, 1'b0, 2'b11);
        cyc(1'b1, 1'b0, 2'b11);
        cyc(1'b1, 1'b0, 2'b11);
        cyc(1'b0, 1'b1, 2'b11);
        cyc(1'b1, 1'b1, 2'b10);
        cyc(1'b1, 1'b0, 2'b10);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0),
                2'($urandom_range(0, 3)));
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
